// File: rtl/execute_mcycle_seq_if.sv
// execute_mcycle_seq_if
// Bundles the execute-stage issue request, the per-unit start/abort/result
// handshake and the writeback/error outputs of the multi-cycle sequencer.
//   master : execute pipeline plus functional units (drives issue and unit results)
//   slave  : the sequencer (drives enables, kills, stall, writeback and errors)
interface execute_mcycle_seq_if #(
  parameter int NUNITS = 4,
  parameter int XLEN   = 32
);
  logic                   issue_valid;
  logic [2:0]             issue_unit;
  logic [4:0]             issue_waddr;
  logic                   clear;
  logic                   hold;
  logic [NUNITS-1:0]      unit_enable;
  logic [NUNITS-1:0]      unit_kill;
  logic [NUNITS-1:0]      unit_ready;
  logic [NUNITS*XLEN-1:0] unit_result;
  logic                   stall;
  logic                   wb_wren;
  logic [4:0]             wb_waddr;
  logic [XLEN-1:0]        wb_wdata;
  logic                   err_timeout;
  logic                   err_unit;

  modport master (
    output issue_valid, issue_unit, issue_waddr, clear, hold, unit_ready, unit_result,
    input  unit_enable, unit_kill, stall, wb_wren, wb_waddr, wb_wdata, err_timeout, err_unit
  );

  modport slave (
    input  issue_valid, issue_unit, issue_waddr, clear, hold, unit_ready, unit_result,
    output unit_enable, unit_kill, stall, wb_wren, wb_waddr, wb_wdata, err_timeout, err_unit
  );
endinterface

// File: rtl/execute_mcycle_seq.sv
// execute_mcycle_seq
// Sequences one multi-cycle functional-unit operation at a time for the
// execute stage: starts the selected unit, stalls the pipeline until the unit
// reports ready, then writes its result back in the same cycle. A flush or a
// timeout aborts the operation with a kill pulse to the unit.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - execute_mcycle_seq_if.slave: issue request, unit handshake,
//          stall, writeback and single-cycle error pulses
// Issue, stall and writeback are decided combinationally from the current
// state so a completing op costs no extra cycle.
module execute_mcycle_seq #(
  parameter int NUNITS  = 4,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  execute_mcycle_seq_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [2:0]  sel_unit;
  logic [4:0]  sel_waddr;
  logic [15:0] cnt;

  logic            unit_legal;
  logic            do_issue;
  logic            busy_live;
  logic            sel_ready;
  logic [XLEN-1:0] sel_data;
  logic            do_done;
  logic            do_flush;
  logic            do_timeout;
  logic            at_limit;

  logic [NUNITS-1:0] enable_vec;
  logic [NUNITS-1:0] kill_vec;

  // Every decision is qualified with !rst so outputs read zero while reset is
  // held, even if the registered state still says BUSY.
  always_comb begin
    unit_legal = int'(bus.issue_unit) < NUNITS;
    do_issue   = !rst && (state == IDLE) && bus.issue_valid && !bus.clear
                 && !bus.hold && unit_legal;
    busy_live  = !rst && (state == BUSY);
    at_limit   = (cnt == 16'(TIMEOUT));

    // Only the latched unit's ready/result matter; all others are ignored.
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (int'(sel_unit) == i) begin
        sel_ready = bus.unit_ready[i];
        sel_data  = bus.unit_result[i*XLEN +: XLEN];
      end
    end

    // Flush outranks both completion and timeout.
    do_flush   = busy_live && bus.clear;
    do_done    = busy_live && !bus.clear && sel_ready;
    do_timeout = busy_live && !bus.clear && !sel_ready && at_limit;

    enable_vec = '0;
    kill_vec   = '0;
    for (int i = 0; i < NUNITS; i++) begin
      enable_vec[i] = do_issue && (int'(bus.issue_unit) == i);
      kill_vec[i]   = (do_flush || do_timeout) && (int'(sel_unit) == i);
    end
  end

  always_comb begin
    bus.unit_enable = enable_vec;
    bus.unit_kill   = kill_vec;
    bus.stall       = do_issue || (busy_live && !bus.clear && !sel_ready && !at_limit);
    // Register x0 is never written: a completion to address 0 just releases the stall.
    bus.wb_wren     = do_done && (sel_waddr != 5'd0);
    bus.wb_waddr    = (do_done && (sel_waddr != 5'd0)) ? sel_waddr : 5'd0;
    bus.wb_wdata    = (do_done && (sel_waddr != 5'd0)) ? sel_data : '0;
    bus.err_timeout = do_timeout;
    bus.err_unit    = !rst && (state == IDLE) && bus.issue_valid && !bus.clear && !unit_legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      sel_unit  <= 3'd0;
      sel_waddr <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (do_issue) begin
            state     <= BUSY;
            sel_unit  <= bus.issue_unit;
            sel_waddr <= bus.issue_waddr;
            cnt       <= 16'd1;
          end
        end
        BUSY: begin
          if (do_flush || do_done || do_timeout) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mcycle_seq.sv
module tb_execute_mcycle_seq;
  localparam int NUNITS = 4;
  localparam int XLEN   = 32;
  localparam int TO     = 4;

  localparam int K_KILL = 0;
  localparam int K_DONE = 1;
  localparam int K_TMO  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  execute_mcycle_seq_if #(.NUNITS(NUNITS), .XLEN(XLEN)) bus ();

  execute_mcycle_seq #(.NUNITS(NUNITS), .XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rstv, input logic valid, input logic [2:0] unit,
                       input logic [4:0] waddr, input logic clr, input logic hld,
                       input logic [NUNITS-1:0] rdy, input logic [NUNITS*XLEN-1:0] res);
    rst             = rstv;
    bus.issue_valid = valid;
    bus.issue_unit  = unit;
    bus.issue_waddr = waddr;
    bus.clear       = clr;
    bus.hold        = hld;
    bus.unit_ready  = rdy;
    bus.unit_result = res;
  endtask

  task automatic check_all(input string tag, input logic [NUNITS-1:0] en, input logic [NUNITS-1:0] kl,
                           input logic st, input logic wr, input logic [4:0] wa,
                           input logic [XLEN-1:0] wd, input logic et, input logic eu);
    chk({tag, ".enable"}, 64'(bus.unit_enable), 64'(en));
    chk({tag, ".kill"},   64'(bus.unit_kill),   64'(kl));
    chk({tag, ".stall"},  64'(bus.stall),       64'(st));
    chk({tag, ".wren"},   64'(bus.wb_wren),     64'(wr));
    chk({tag, ".waddr"},  64'(bus.wb_waddr),    64'(wa));
    chk({tag, ".wdata"},  64'(bus.wb_wdata),    64'(wd));
    chk({tag, ".err_to"}, 64'(bus.err_timeout), 64'(et));
    chk({tag, ".err_un"}, 64'(bus.err_unit),    64'(eu));
  endtask

  function automatic logic [NUNITS*XLEN-1:0] rand_results();
    logic [NUNITS*XLEN-1:0] r;
    for (int i = 0; i < NUNITS; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  // Transaction-level reference: op issued at relative cycle 0, the unit's
  // ready shows up at cycle lat, optional flush at cycle clr_at (0 = none).
  // The op ends at the earliest of flush, ready, or cycle TO; the pipeline is
  // stalled for every cycle before the end cycle.
  task automatic run_op(input string tag, input int unit, input logic [4:0] waddr,
                        input int lat, input int clr_at, input logic [XLEN-1:0] res);
    int lim, end_k, kind;
    logic [NUNITS-1:0] rdy, en, kl;
    logic [NUNITS*XLEN-1:0] rv;
    logic wr;
    lim = (lat <= TO) ? lat : TO;
    if (clr_at != 0 && clr_at <= lim) begin
      end_k = clr_at; kind = K_KILL;
    end else if (lat <= TO) begin
      end_k = lat; kind = K_DONE;
    end else begin
      end_k = TO; kind = K_TMO;
    end
    for (int k = 0; k <= end_k; k++) begin
      rdy = NUNITS'($urandom);
      if (k > 0) rdy[unit] = (k == lat);
      rv = rand_results();
      rv[unit*XLEN +: XLEN] = res;
      drive(1'b0, k == 0, 3'(unit), waddr, (clr_at != 0) && (k == clr_at), 1'b0, rdy, rv);
      #1;
      en = '0; kl = '0; wr = 1'b0;
      if (k == 0) en[unit] = 1'b1;
      if (k == end_k && kind != K_DONE) kl[unit] = 1'b1;
      if (k == end_k && kind == K_DONE) wr = (waddr != 5'd0);
      check_all(tag, en, kl, k < end_k, wr, wr ? waddr : 5'd0, wr ? res : '0,
                (k == end_k) && (kind == K_TMO), 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic idle_step(input string tag, input logic valid, input logic [2:0] unit,
                           input logic clr, input logic hld);
    drive(1'b0, valid, unit, 5'($urandom), clr, hld, NUNITS'($urandom), rand_results());
    #1;
    check_all(tag, '0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0,
              valid && (int'(unit) >= NUNITS) && !clr);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Reset overrides an otherwise valid issue with ready asserted.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 3'd0, 5'd3, 1'b0, 1'b0, '1, rand_results());
      #1;
      check_all("reset", '0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // First cycle out of reset accepts the issue.
    rst = 1'b0;
    run_op("basic_u0", 0, 5'd5, 3, 0, 32'h0000_002A);
    idle_step("no_reissue", 1'b0, 3'd0, 1'b0, 1'b0);
    run_op("waddr0", 2, 5'd0, 1, 0, 32'hDEAD_BEEF);
    run_op("clear_vs_ready", 1, 5'd7, 2, 2, 32'h1234_5678);
    run_op("timeout_u3", 3, 5'd9, 100, 0, 32'h0);
    idle_step("illegal_unit", 1'b1, 3'd5, 1'b0, 1'b0);
    idle_step("hold", 1'b1, 3'd1, 1'b0, 1'b1);
    idle_step("idle_clear", 1'b1, 3'd2, 1'b1, 1'b0);
    // Back-to-back: completion then enable on the very next cycle.
    run_op("b2b_a", 1, 5'd11, 2, 0, 32'hAAAA_0001);
    run_op("b2b_b", 2, 5'd12, TO, 0, 32'hBBBB_0002);

    // Reset mid-BUSY with the selected unit ready: no writeback, no kill.
    drive(1'b0, 1'b1, 3'd0, 5'd4, 1'b0, 1'b0, '0, rand_results());
    #1;
    check_all("rst_busy.issue", 4'b0001, '0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 4'b0001, rand_results());
    #1;
    check_all("rst_busy.rst", '0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 4'b0001, rand_results());
    #1;
    check_all("rst_busy.after", '0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    @(negedge clk);

    // Randomized operations with idle noise in between.
    for (int n = 0; n < 60; n++) begin
      int gaps, sel;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: idle_step("rnd_idle", 1'b0, 3'($urandom), 1'b0, 1'b0);
          1: idle_step("rnd_illegal", 1'b1, 3'($urandom_range(4, 7)), 1'($urandom), 1'b0);
          2: idle_step("rnd_hold", 1'b1, 3'($urandom_range(0, 3)), 1'($urandom), 1'b1);
          default: idle_step("rnd_clear", 1'b1, 3'($urandom_range(0, 3)), 1'b1, 1'($urandom));
        endcase
      end
      run_op("rnd_op", $urandom_range(0, NUNITS - 1),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             $urandom_range(1, TO + 2),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 1) : 0,
             $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_mcycle_seq.md
EXECUTE_MCYCLE_SEQ -- requirements
Module: execute_mcycle_seq

Interface
REQ-001 SHALL have parameter NUNITS, default 4, number of multi-cycle functional units (div, mul, clmul, spare); legal range 1..8.
REQ-002 SHALL have parameter XLEN, default 32, result data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum BUSY cycles before abort; legal range 2..65535.
REQ-004 SHALL have ports clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid  in  1  execute-stage instruction needs a multi-cycle unit.
REQ-007 SHALL have port issue_unit  in  3  unit index; index >= NUNITS illegal.
REQ-008 SHALL have port issue_waddr  in  5  destination register.
REQ-009 SHALL have port clear  in  1  pipeline flush.
REQ-010 SHALL have port hold  in  1  upstream stall; blocks new issue.
REQ-011 SHALL have port unit_enable  out  NUNITS  one-hot start pulse.
REQ-012 SHALL have port unit_kill  out  NUNITS  one-hot abort pulse.
REQ-013 SHALL have port unit_ready  in  NUNITS  per-unit result valid.
REQ-014 SHALL have port unit_result  in  NUNITS*XLEN  packed results, unit i at bits [i*XLEN +: XLEN].
REQ-015 SHALL have port stall  out  1  execute stage must hold.
REQ-016 SHALL have port wb_wren  out  1  register write strobe.
REQ-017 SHALL have port wb_waddr  out  5; wb_wdata  out  XLEN.
REQ-018 SHALL have port err_timeout  out  1; err_unit  out  1  single-cycle error pulses.

Function
REQ-019 SHALL implement FSM states IDLE and BUSY, plus registered sel_unit, sel_waddr and 16-bit cycle counter cnt.
REQ-020 IDLE, issue_valid=1, clear=0, hold=0, issue_unit<NUNITS: SHALL pulse unit_enable[issue_unit] that cycle, assert stall combinationally, latch unit/waddr, cnt<=1, go BUSY.
REQ-021 IDLE, issue_valid=1, issue_unit>=NUNITS, clear=0: SHALL pulse err_unit, no enable, no stall, stay IDLE.
REQ-022 IDLE with clear=1 or hold=1: SHALL issue nothing, stall=0, stay IDLE.
REQ-023 BUSY, unit_ready[sel_unit]=0, clear=0: stall=1, cnt increments, stay BUSY.
REQ-024 BUSY, unit_ready[sel_unit]=1, clear=0: stall=0, wb_wren=|sel_waddr, wb_waddr=sel_waddr, wb_wdata=result of sel_unit, same cycle (zero added latency), go IDLE.
REQ-025 BUSY, clear=1 (regardless of ready): SHALL pulse unit_kill[sel_unit], wb_wren=0, stall=0, go IDLE; clear has priority over ready and timeout.
REQ-026 BUSY, cnt=TIMEOUT and ready=0, clear=0: SHALL pulse err_timeout and unit_kill[sel_unit], wb_wren=0, stall=0, go IDLE.
REQ-027 unit_ready of non-selected units and any unit_ready in IDLE SHALL be ignored.
REQ-028 Cycle after completion SHALL NOT re-issue unless issue_valid is presented while IDLE; back-to-back ops: completion cycle N, next enable earliest N+1.
REQ-029 unit_enable, unit_kill SHALL never have more than one bit set and never both nonzero in one cycle.
REQ-030 wb_wren SHALL be 0 whenever stall=1.
REQ-031 Outputs wb_waddr/wb_wdata SHALL be 0 when wb_wren=0.

Reset
REQ-032 rst=1 at clock edge SHALL force IDLE, cnt=0, sel_unit=0, sel_waddr=0, overriding all inputs.
REQ-033 During/after reset, all outputs SHALL be 0; reset mid-BUSY SHALL drop the op with no kill pulse and no writeback.
REQ-034 First issue SHALL be accepted on the first cycle with rst=0.

Verification
REQ-035 Issue unit 0, waddr 5; unit_ready[0] asserted 3 cycles after enable with result 0x0000_002A -> stall high 3 cycles, then wb_wren=1, waddr 5, wdata 0x2A, stall 0.
REQ-036 Issue unit 2, waddr 0, ready after 1 cycle -> wb_wren=0, stall released, no write.
REQ-037 Issue unit 1, clear asserted 2 cycles later coincident with unit_ready[1] -> unit_kill=0010, wb_wren=0, state IDLE.
REQ-038 TIMEOUT=4, unit 3 never ready -> stall 4 cycles, err_timeout and unit_kill=1000 on cycle 4, then IDLE.
REQ-039 issue_unit=5 with NUNITS=4 -> err_unit pulse, unit_enable=0, stall=0; hold=1 with valid issue -> no enable.
REQ-040 rst asserted mid-BUSY with unit_ready[0] high same cycle -> no writeback; all outputs 0 next cycle.
